sp_addsub_pipe: RTL and testbench
=================================

Name: sp_addsub_pipe

Overview:
- Two-stage valid/ready pipeline that fronts the combinational single-precision adder and subtractor units.
- Accepts (a, b, op) transactions and resolves the effective operation from the operand signs.
- The subtractor only handles same-sign operands. This block applies that restriction and routes each operation to the correct unit, or bypasses both for zero operands.
- Registers the selected result with a passthrough tag. Sits between the FFT butterfly sequencer and the combinational FP units.

Parameters:
- TAG_W, 4, width of the opaque tag carried alongside each transaction.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream transaction valid
- in_ready  output  1  block can accept a transaction this cycle
- in_op  input  1  0 = a+b, 1 = a-b
- in_a  input  32  SP operand a
- in_b  input  32  SP operand b
- in_tag  input  TAG_W  tag, returned unchanged with the result
- add_a  output  32  adder operand a
- add_b  output  32  adder operand b
- add_z  input  32  adder result (combinational from add_a/add_b)
- sub_a  output  32  subtractor operand a (same sign as sub_b)
- sub_b  output  32  subtractor operand b
- sub_z  input  32  subtractor result (combinational from sub_a/sub_b)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_z  output  32  SP result
- out_tag  output  TAG_W  tag of this result
- out_path  output  2  0 = adder, 1 = subtractor, 2 = bypass

Behaviour:
- Reset (async, rst_n low):
  - s1_valid and s2_valid are cleared.
  - out_z, out_tag and out_path are 0. out_valid is 0.
  - Operand ports are 0.
  - In-flight transactions are dropped. No output appears after reset releases.
- S1 capture: on in_valid && in_ready, register a, b, op and tag.
  - Effective b: b' = op ? {~b[31], b[30:0]} : b.
- Zero operand: a value is zero when bits [30:0] == 0, either sign.
- S1 dispatch, combinational from the S1 registers:
  - a zero or b' zero: bypass.
    - Both zero: result 32'h0.
    - Only a zero: result b'.
    - Only b' zero: result a.
  - Otherwise a[31] == b'[31]: adder path. add_a = a, add_b = b'.
  - Otherwise: subtractor path. sub_a = a, sub_b = {a[31], b'[30:0]}.
- Unit operand ports:
  - Ports of the unit not selected, or all ports when s1_valid = 0, are driven to 32'h0.
  - Selected operands stay stable for every cycle S1 holds the transaction, including stall cycles.
- S2 capture: when s1_valid && s2_accept, register:
  - the selected result (add_z, sub_z or the bypass value);
  - the tag;
  - the path code.
  - Then set s2_valid.
- Flow control:
  - s2_accept = !s2_valid || out_ready.
  - S1 advances when s1_valid && s2_accept.
  - in_ready = !s1_valid || s2_accept. This is a combinational path from out_ready to in_ready, and it is intended.
  - out_valid = s2_valid. The S2 registers hold while out_valid && !out_ready.
  - s2_valid clears on out_ready when S1 is not advancing.
- Latency and throughput:
  - Latency is 2 cycles from input accept to out_valid.
  - Throughput is 1 transaction per cycle with out_ready held high.
  - Results come out strictly in input order.
- Simultaneous input accept and S1 advance in the same cycle: S1 reloads with the new transaction. No bubble is inserted.
- NaN, infinity and denormals: no special handling. The block passes the unit results unchanged.

Optional Feature:
- Macro: SP_ADDSUB_STATS_EN.
- Defined:
  - Adds output ports cnt_add, cnt_sub and cnt_byp, each 16 bits.
  - Each counter increments on S2 capture for its path code.
  - Counters wrap from 16'hFFFF to 0.
  - Counters clear on async reset.
- Undefined: the ports and counters are absent. Datapath behaviour is identical in both builds.

Test Plan:
- Add, adder path: in_op=0, a=3F800000, b=3F800000, adder model returns the true sum.
  - Expect add_a = add_b = 3F800000.
  - Expect out_z = 40000000, out_path = 0, out_valid 2 cycles after accept.
- Subtract, subtractor path: in_op=1, a=40400000, b=3F800000.
  - Expect sub_a = 40400000, sub_b = 3F800000.
  - Expect out_z = 40000000, out_path = 1.
- Sign resolution:
  - in_op=0, a=40400000, b=BF800000: expect subtractor path, sub_b = 3F800000, out_z = 40000000.
  - in_op=1, a=40400000, b=BF800000: expect adder path, add_b = 3F800000, out_z = 40800000.
- Bypass:
  - in_op=1, a=80000000, b=40000000: expect out_z = C0000000, out_path = 2, both units' operands stay 0.
  - in_op=0, a=00000000, b=80000000: expect out_z = 00000000.
- Backpressure: stream tags 1..4 back-to-back with out_ready low for 4 cycles.
  - Expect in_ready low after 2 accepts.
  - After release, expect tags out in order 1,2,3,4 with no loss or duplication, and operand ports stable while stalled.
- Reset mid-stream: assert rst_n low while S1 and S2 are both full.
  - Expect out_valid = 0, out_z = 0, out_tag = 0 and operand ports 0 immediately.
  - After release, expect no stale output. With SP_ADDSUB_STATS_EN, expect counters 0.

Source files
------------

// File: rtl/sp_addsub_pipe_if.sv
// Handshake and FP-unit bus for sp_addsub_pipe.
// slave = pipeline view, master = upstream/downstream/FP-unit environment view.
`timescale 1ns/1ps
interface sp_addsub_pipe_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;

    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_z;
    logic [31:0]      sub_a;
    logic [31:0]      sub_b;
    logic [31:0]      sub_z;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_z;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       out_path;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, add_z, sub_z, out_ready,
        output in_ready, add_a, add_b, sub_a, sub_b, out_valid, out_z, out_tag, out_path
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, add_z, sub_z, out_ready,
        input  in_ready, add_a, add_b, sub_a, sub_b, out_valid, out_z, out_tag, out_path
    );
endinterface

// File: rtl/sp_addsub_pipe.sv
// Purpose: 2-stage front end routing SP a+/-b to adder, same-sign subtractor or zero bypass; SP_ADDSUB_STATS_EN adds per-path counters.
// Latency: 2 cycles accept-to-out_valid, 1 txn/cycle with out_ready high.
// Backpressure: S2 holds while !out_ready; in_ready combinationally follows out_ready when both stages are full.
`timescale 1ns/1ps
module sp_addsub_pipe #(
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sp_addsub_pipe_if.slave      bus
`ifdef SP_ADDSUB_STATS_EN
    ,
    output logic [15:0]          cnt_add,
    output logic [15:0]          cnt_sub,
    output logic [15:0]          cnt_byp
`endif
);

    typedef enum logic [1:0] {
        PATH_ADD = 2'd0,
        PATH_SUB = 2'd1,
        PATH_BYP = 2'd2
    } path_e;

    logic             r_s1_vld;
    logic             r_s1_op;
    logic [31:0]      r_s1_a;
    logic [31:0]      r_s1_b;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_vld;
    logic [31:0]      r_s2_z;
    logic [TAG_W-1:0] r_s2_tag;
    path_e            r_s2_path;

    logic             w_s2_accept;
    logic             w_s1_adv;
    logic             w_in_ready;
    logic             w_in_fire;
    logic [31:0]      w_b_eff;
    logic             w_a_zero;
    logic             w_b_zero;
    path_e            w_path;
    logic [31:0]      w_byp_z;
    logic [31:0]      w_sel_z;

    assign w_s2_accept = !r_s2_vld || bus.out_ready;
    assign w_s1_adv    = r_s1_vld && w_s2_accept;
    assign w_in_ready  = !r_s1_vld || w_s2_accept;
    assign w_in_fire   = bus.in_valid && w_in_ready;

    // Subtraction is folded into an addition of the sign-flipped operand.
    assign w_b_eff  = {r_s1_b[31] ^ r_s1_op, r_s1_b[30:0]};
    assign w_a_zero = (r_s1_a[30:0] == 31'd0);
    assign w_b_zero = (w_b_eff[30:0] == 31'd0);

    always_comb begin
        w_path  = PATH_BYP;
        w_byp_z = 32'h0;
        if (w_a_zero || w_b_zero) begin
            w_path = PATH_BYP;
            if (w_a_zero && !w_b_zero) begin
                w_byp_z = w_b_eff;
            end else if (!w_a_zero) begin
                w_byp_z = r_s1_a;
            end
        end else if (r_s1_a[31] == w_b_eff[31]) begin
            w_path = PATH_ADD;
        end else begin
            w_path = PATH_SUB;
        end
    end

    // The subtractor only sees same-sign operands: b takes a's sign.
    always_comb begin
        bus.add_a = 32'h0;
        bus.add_b = 32'h0;
        bus.sub_a = 32'h0;
        bus.sub_b = 32'h0;
        if (r_s1_vld) begin
            case (w_path)
                PATH_ADD: begin
                    bus.add_a = r_s1_a;
                    bus.add_b = w_b_eff;
                end
                PATH_SUB: begin
                    bus.sub_a = r_s1_a;
                    bus.sub_b = {r_s1_a[31], w_b_eff[30:0]};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (w_path)
            PATH_ADD: w_sel_z = bus.add_z;
            PATH_SUB: w_sel_z = bus.sub_z;
            default:  w_sel_z = w_byp_z;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_op  <= 1'b0;
            r_s1_a   <= 32'h0;
            r_s1_b   <= 32'h0;
            r_s1_tag <= '0;
        end else begin
            if (w_in_ready) begin
                r_s1_vld <= bus.in_valid;
            end
            if (w_in_fire) begin
                r_s1_op  <= bus.in_op;
                r_s1_a   <= bus.in_a;
                r_s1_b   <= bus.in_b;
                r_s1_tag <= bus.in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_z    <= 32'h0;
            r_s2_tag  <= '0;
            r_s2_path <= PATH_ADD;
        end else begin
            if (w_s2_accept) begin
                r_s2_vld <= r_s1_vld;
            end
            if (w_s1_adv) begin
                r_s2_z    <= w_sel_z;
                r_s2_tag  <= r_s1_tag;
                r_s2_path <= w_path;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_vld;
    assign bus.out_z     = r_s2_z;
    assign bus.out_tag   = r_s2_tag;
    assign bus.out_path  = r_s2_path;

`ifdef SP_ADDSUB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_add <= 16'h0;
            cnt_sub <= 16'h0;
            cnt_byp <= 16'h0;
        end else if (w_s1_adv) begin
            case (w_path)
                PATH_ADD: cnt_add <= cnt_add + 16'd1;
                PATH_SUB: cnt_sub <= cnt_sub + 16'd1;
                default:  cnt_byp <= cnt_byp + 16'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_sp_addsub_pipe.sv
// Directed-vector bench for sp_addsub_pipe with an expected-result queue drained by an output monitor.
// FP units are table models covering exactly the operand pairs the vectors produce.
`timescale 1ns/1ps
module tb_sp_addsub_pipe;

    typedef struct packed {
        logic [31:0] z;
        logic [3:0]  tag;
        logic [1:0]  path;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   n_add;
    int   n_sub;
    int   n_byp;
    exp_t sbq[$];

    sp_addsub_pipe_if #(.TAG_W(4)) bus ();

`ifdef SP_ADDSUB_STATS_EN
    logic [15:0] cnt_add;
    logic [15:0] cnt_sub;
    logic [15:0] cnt_byp;
`endif

    sp_addsub_pipe #(.TAG_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus)
`ifdef SP_ADDSUB_STATS_EN
        ,
        .cnt_add (cnt_add),
        .cnt_sub (cnt_sub),
        .cnt_byp (cnt_byp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {32'h40400000, 32'h3F800000}: return 32'h40800000;
            {32'hBF800000, 32'hBF800000}: return 32'hC0000000;
            {32'h00000000, 32'h00000000}: return 32'h00000000;
            default:                      return 32'h7FC0DEAD;
        endcase
    endfunction

    function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40400000, 32'h3F800000}: return 32'h40000000;
            {32'h00000000, 32'h00000000}: return 32'h00000000;
            default:                      return 32'h7FC0BEEF;
        endcase
    endfunction

    always_comb begin
        bus.add_z = fadd(bus.add_a, bus.add_b);
        bus.sub_z = fsub(bus.sub_a, bus.sub_b);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic chk_ops(input string nm, input logic [31:0] aa, input logic [31:0] ab,
                           input logic [31:0] sa, input logic [31:0] sb);
        chk({nm, ".add_a"}, bus.add_a, aa);
        chk({nm, ".add_b"}, bus.add_b, ab);
        chk({nm, ".sub_a"}, bus.sub_a, sa);
        chk({nm, ".sub_b"}, bus.sub_b, sb);
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [3:0] tag, input logic [31:0] ez, input logic [1:0] ep);
        int   guard;
        bit   acc;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_tag   = tag;
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 50) begin
            #3;
            acc = bus.in_ready;
            if (acc) begin
                e.z    = ez;
                e.tag  = tag;
                e.path = ep;
                sbq.push_back(e);
            end
            @(negedge clk);
            guard++;
        end
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: tag %0d not accepted within %0d cycles", tag, guard);
        end
    endtask

    task automatic single(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic [3:0] tag, input logic [31:0] ez,
                          input logic [1:0] ep, input logic [31:0] aa, input logic [31:0] ab,
                          input logic [31:0] sa, input logic [31:0] sb);
        send(a, b, op, tag, ez, ep);
        bus.in_valid = 1'b0;
        #1;
        chk_ops(nm, aa, ab, sa, sb);
        chk({nm, ".valid_at_1"}, {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk({nm, ".valid_at_2"}, {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got tag %0d z %h, required no output",
                             bus.out_tag, bus.out_z);
                end else begin
                    e = sbq.pop_front();
                    chk("out_z", bus.out_z, e.z);
                    chk("out_tag", {28'd0, bus.out_tag}, {28'd0, e.tag});
                    chk("out_path", {30'd0, bus.out_path}, {30'd0, e.path});
                    case (e.path)
                        2'd0:    n_add++;
                        2'd1:    n_sub++;
                        default: n_byp++;
                    endcase
                end
            end
        end
    end

    initial begin : main
        n_chk = 0; n_fail = 0; n_add = 0; n_sub = 0; n_byp = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 1'b0;
        bus.in_a      = 32'h0;
        bus.in_b      = 32'h0;
        bus.in_tag    = 4'h0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst.out_z", bus.out_z, 32'h0);
        chk("rst.out_tag", {28'd0, bus.out_tag}, 32'd0);
        chk("rst.out_path", {30'd0, bus.out_path}, 32'd0);
        chk_ops("rst", 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        single("add",      32'h3F800000, 32'h3F800000, 1'b0, 4'd1, 32'h40000000, 2'd0,
               32'h3F800000, 32'h3F800000, 32'h0, 32'h0);
        single("sub",      32'h40400000, 32'h3F800000, 1'b1, 4'd2, 32'h40000000, 2'd1,
               32'h0, 32'h0, 32'h40400000, 32'h3F800000);
        single("sgn_sub",  32'h40400000, 32'hBF800000, 1'b0, 4'd3, 32'h40000000, 2'd1,
               32'h0, 32'h0, 32'h40400000, 32'h3F800000);
        single("sgn_add",  32'h40400000, 32'hBF800000, 1'b1, 4'd4, 32'h40800000, 2'd0,
               32'h40400000, 32'h3F800000, 32'h0, 32'h0);
        single("byp_a0",   32'h80000000, 32'h40000000, 1'b1, 4'd5, 32'hC0000000, 2'd2,
               32'h0, 32'h0, 32'h0, 32'h0);
        single("byp_both", 32'h00000000, 32'h80000000, 1'b0, 4'd6, 32'h00000000, 2'd2,
               32'h0, 32'h0, 32'h0, 32'h0);
        single("byp_b0",   32'h40400000, 32'h80000000, 1'b1, 4'd7, 32'h40400000, 2'd2,
               32'h0, 32'h0, 32'h0, 32'h0);

        // Backpressure: two accepts fill both stages, then the third must wait.
        bus.out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b0, 4'd1, 32'h40000000, 2'd0);
        send(32'h40400000, 32'h3F800000, 1'b1, 4'd2, 32'h40000000, 2'd1);
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 32'h80000000;
            bus.in_b     = 32'h40000000;
            bus.in_op    = 1'b1;
            bus.in_tag   = 4'd3;
            #3;
            chk("bp.in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp.out_tag_hold", {28'd0, bus.out_tag}, 32'd1);
            chk_ops("bp.stall", 32'h0, 32'h0, 32'h40400000, 32'h3F800000);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        send(32'h80000000, 32'h40000000, 1'b1, 4'd3, 32'hC0000000, 2'd2);
        send(32'hBF800000, 32'hBF800000, 1'b0, 4'd4, 32'hC0000000, 2'd0);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp.drained", sbq.size(), 32'd0);
`ifdef SP_ADDSUB_STATS_EN
        chk("cnt_add", {16'd0, cnt_add}, n_add);
        chk("cnt_sub", {16'd0, cnt_sub}, n_sub);
        chk("cnt_byp", {16'd0, cnt_byp}, n_byp);
`endif

        // Reset while both stages hold transactions.
        bus.out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b0, 4'd9, 32'h40000000, 2'd0);
        send(32'h40400000, 32'h3F800000, 1'b1, 4'd10, 32'h40000000, 2'd1);
        bus.in_valid = 1'b0;
        #1;
        chk("pre_rst.out_valid", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("mid_rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst.out_z", bus.out_z, 32'h0);
        chk("mid_rst.out_tag", {28'd0, bus.out_tag}, 32'd0);
        chk_ops("mid_rst", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("post_rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        end
`ifdef SP_ADDSUB_STATS_EN
        chk("post_rst.cnt_add", {16'd0, cnt_add}, 32'd0);
        chk("post_rst.cnt_sub", {16'd0, cnt_sub}, 32'd0);
        chk("post_rst.cnt_byp", {16'd0, cnt_byp}, 32'd0);
`endif
        chk("final.queue_empty", sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
